plic_seq_arbiter: RTL and testbench
===================================

PLIC_SEQ_ARBITER -- requirements
Module: plic_seq_arbiter

Interface
REQ-001 Parameter NUM_IRQ, default 1024, is the number of interrupt sources; IRQ 0 is reserved and never eligible.
REQ-002 Parameter PRIO_BIT, default 5, is the priority field width.
REQ-003 Parameter LANES, default 8, is the number of sources compared per cycle; NUM_IRQ SHALL be a multiple of LANES (elaboration error otherwise).
REQ-004 Derived constant NUM_STEPS = NUM_IRQ/LANES; ID_W = $clog2(NUM_IRQ).
REQ-005 pclk_i  in  1  sole clock; rising edge.
REQ-006 prst_i  in  1  reset, asynchronous, active-high.
REQ-007 en_i  in  1  scan enable for this hart/context.
REQ-008 int_pending_i  in  NUM_IRQ  synchronized pending bits.
REQ-009 int_en_i  in  NUM_IRQ  per-source enable for this context.
REQ-010 pri_lvl_i  in  NUM_IRQ*PRIO_BIT  packed priorities, source i at [i*PRIO_BIT +: PRIO_BIT].
REQ-011 threshold_i  in  PRIO_BIT  context threshold.
REQ-012 claim_req_i  in  1  single-cycle claim pulse.
REQ-013 winner_id_o  out  ID_W  registered winning source id.
REQ-014 winner_prio_o  out  PRIO_BIT  registered winning priority.
REQ-015 irq_o  out  1  registered interrupt request to the hart.
REQ-016 scan_done_o  out  1  one-cycle pulse in the UPDATE cycle.
REQ-017 claim_ack_o  out  1  one-cycle pulse, cycle after claim_req_i.
REQ-018 claim_id_o  out  ID_W  id returned with claim_ack_o; 0 otherwise.

Function
REQ-019 FSM states IDLE, SCAN, UPDATE; IDLE->SCAN when en_i=1; SCAN->UPDATE after step counter reaches NUM_STEPS-1; UPDATE->SCAN (en_i=1) or IDLE (en_i=0).
REQ-020 Any state ->IDLE on en_i=0; entering IDLE clears winner_id_o, winner_prio_o, irq_o, running best.
REQ-021 In SCAN step s, sources s*LANES..s*LANES+LANES-1 are evaluated; eligible = pending & enable & prio!=0 & id!=0.
REQ-022 Running best replaced only by strictly greater priority; ties resolve to the lowest id.
REQ-023 Running best and step counter clear on SCAN entry; scan period is NUM_STEPS+1 cycles.
REQ-024 In UPDATE: winner_id_o/winner_prio_o <= running best (0/0 if none eligible); irq_o <= (best prio > threshold_i), threshold_i sampled only in UPDATE.
REQ-025 Inputs changing mid-scan affect only steps not yet evaluated; no input capture buffering.
REQ-026 claim_req_i: next cycle claim_ack_o=1, claim_id_o = winner_id_o if irq_o=1 else 0.
REQ-027 Claim in same cycle clears winner_id_o, winner_prio_o, irq_o and restarts SCAN at step 0 with cleared best.
REQ-028 Claim coinciding with UPDATE: claim returns pre-update registered winner; update discarded; scan restarts.
REQ-029 Claim while irq_o=0 or in IDLE: ack with id 0; IDLE state unchanged.
REQ-030 scan_done_o not asserted in an UPDATE cycle discarded by claim.

Reset
REQ-031 prst_i asserted: state IDLE, step 0, all outputs 0, immediately (asynchronous).
REQ-032 Reset mid-scan or mid-claim discards all partial results; no ack issued for a claim in flight.
REQ-033 First SCAN begins in the first cycle after prst_i deasserts with en_i=1.

Structure
REQ-034 Shared package plic_pkg SHALL hold the state enum typedef and the NUM_STEPS/ID_W derivation functions.
REQ-035 One sub-module plic_max_tree: combinational LANES-input max-with-lowest-id-tiebreak, instanced once.
REQ-036 Implementation target 120-400 lines; no memories, no multicycle paths.

Verification (NUM_IRQ=64, LANES=8, PRIO_BIT=5)
REQ-037 Reset then en_i=1, none pending -> scan_done_o every 9 cycles, winner 0/0, irq_o=0.
REQ-038 IRQ 5 prio 3, IRQ 40 prio 3, both enabled, threshold 2 -> winner_id_o=5, irq_o=1 after first scan_done_o.
REQ-039 IRQ 63 prio 7 enabled, threshold 7 -> winner_id_o=63, winner_prio_o=7, irq_o=0.
REQ-040 Winner 12 with irq_o=1, claim_req_i pulsed in UPDATE cycle -> claim_ack_o with claim_id_o=12, irq_o=0, step counter 0 next cycle.
REQ-041 en_i dropped mid-scan at step 4 -> IDLE next cycle, outputs 0; claim then -> ack id 0.
REQ-042 prst_i asserted at step 6 with pending IRQ 20 -> outputs 0 asynchronously; after release, winner 20 reported at 9th cycle.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC sequential arbiter.
// Holds the arbiter FSM state type and the helpers that derive
// the scan length and the source-id width from the block parameters.
package plic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  // Number of SCAN cycles needed to visit every source, LANES at a time.
  function automatic int num_steps(input int num_irq, input int lanes);
    return num_irq / lanes;
  endfunction

  // Width of a source id; never narrower than one bit.
  function automatic int id_w(input int num_irq);
    return (num_irq > 1) ? $clog2(num_irq) : 1;
  endfunction

endpackage

// File: rtl/plic_max_tree.sv
// Combinational LANES-input maximum selector.
// Picks the valid lane with the highest priority; equal priorities
// resolve to the lowest id.
//   vld_i  : per-lane eligible flags
//   prio_i : packed per-lane priorities (lane l at [l*PRIO_BIT +: PRIO_BIT])
//   id_i   : packed per-lane source ids  (lane l at [l*ID_W +: ID_W])
//   vld_o  : at least one lane was eligible
//   prio_o : winning priority (0 when none)
//   id_o   : winning id (0 when none)
module plic_max_tree #(
  parameter int LANES    = 8,
  parameter int PRIO_BIT = 5,
  parameter int ID_W     = 10
) (
  input  logic [LANES-1:0]          vld_i,
  input  logic [LANES*PRIO_BIT-1:0] prio_i,
  input  logic [LANES*ID_W-1:0]     id_i,
  output logic                      vld_o,
  output logic [PRIO_BIT-1:0]       prio_o,
  output logic [ID_W-1:0]           id_o
);

  always_comb begin
    vld_o  = 1'b0;
    prio_o = '0;
    id_o   = '0;
    for (int l = 0; l < LANES; l++) begin
      if (vld_i[l]) begin
        if (!vld_o ||
            (prio_i[l*PRIO_BIT +: PRIO_BIT] > prio_o) ||
            ((prio_i[l*PRIO_BIT +: PRIO_BIT] == prio_o) &&
             (id_i[l*ID_W +: ID_W] < id_o))) begin
          vld_o  = 1'b1;
          prio_o = prio_i[l*PRIO_BIT +: PRIO_BIT];
          id_o   = id_i[l*ID_W +: ID_W];
        end
      end
    end
  end

endmodule

// File: rtl/plic_seq_arbiter.sv
// Sequential PLIC target arbiter for one hart context.
// Scans NUM_IRQ sources LANES per cycle, keeps a running best
// (highest priority, lowest id on ties) and publishes it once per scan.
//   pclk_i / prst_i  : clock, async active-high reset
//   en_i             : scan enable
//   int_pending_i    : pending bits, int_en_i : per-source enables
//   pri_lvl_i        : packed priorities, threshold_i : context threshold
//   claim_req_i      : claim pulse -> claim_ack_o / claim_id_o next cycle
//   winner_id_o / winner_prio_o / irq_o : registered result
//   scan_done_o      : pulse during an UPDATE cycle that commits
module plic_seq_arbiter
  import plic_pkg::*;
#(
  parameter int NUM_IRQ  = 1024,
  parameter int PRIO_BIT = 5,
  parameter int LANES    = 8,
  localparam int NUM_STEPS = num_steps(NUM_IRQ, LANES),
  localparam int ID_W      = id_w(NUM_IRQ)
) (
  input  logic                         pclk_i,
  input  logic                         prst_i,
  input  logic                         en_i,
  input  logic [NUM_IRQ-1:0]           int_pending_i,
  input  logic [NUM_IRQ-1:0]           int_en_i,
  input  logic [NUM_IRQ*PRIO_BIT-1:0]  pri_lvl_i,
  input  logic [PRIO_BIT-1:0]          threshold_i,
  input  logic                         claim_req_i,
  output logic [ID_W-1:0]              winner_id_o,
  output logic [PRIO_BIT-1:0]          winner_prio_o,
  output logic                         irq_o,
  output logic                         scan_done_o,
  output logic                         claim_ack_o,
  output logic [ID_W-1:0]              claim_id_o
);

  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int PIDX_W = $clog2(NUM_IRQ * PRIO_BIT);

  if ((NUM_IRQ % LANES) != 0) begin : g_bad_cfg
    $error("plic_seq_arbiter: NUM_IRQ must be a multiple of LANES");
  end

  state_e                state_q;
  logic [STEP_W-1:0]     step_q;
  logic [ID_W-1:0]       best_id_q;
  logic [PRIO_BIT-1:0]   best_prio_q;
  logic [ID_W-1:0]       winner_id_q;
  logic [PRIO_BIT-1:0]   winner_prio_q;
  logic                  irq_q;
  logic                  claim_ack_q;
  logic [ID_W-1:0]       claim_id_q;

  logic [LANES-1:0]          lane_vld;
  logic [LANES*PRIO_BIT-1:0] lane_prio;
  logic [LANES*ID_W-1:0]     lane_id;
  logic                      tree_vld;
  logic [PRIO_BIT-1:0]       tree_prio;
  logic [ID_W-1:0]           tree_id;

  // Slice of sources belonging to the current step, read live from the
  // inputs so that changes only affect steps not yet visited.
  always_comb begin
    logic [ID_W-1:0]     lid;
    logic [PRIO_BIT-1:0] lprio;
    lane_vld  = '0;
    lane_prio = '0;
    lane_id   = '0;
    for (int l = 0; l < LANES; l++) begin
      lid   = ID_W'(step_q) * ID_W'(LANES) + ID_W'(l);
      lprio = pri_lvl_i[PIDX_W'(lid) * PIDX_W'(PRIO_BIT) +: PRIO_BIT];
      lane_vld[l]                      = int_pending_i[lid] & int_en_i[lid] &
                                         (lprio != '0) & (lid != '0);
      lane_prio[l*PRIO_BIT +: PRIO_BIT] = lprio;
      lane_id[l*ID_W +: ID_W]           = lid;
    end
  end

  plic_max_tree #(
    .LANES    (LANES),
    .PRIO_BIT (PRIO_BIT),
    .ID_W     (ID_W)
  ) u_max_tree (
    .vld_i  (lane_vld),
    .prio_i (lane_prio),
    .id_i   (lane_id),
    .vld_o  (tree_vld),
    .prio_o (tree_prio),
    .id_o   (tree_id)
  );

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_q       <= ST_IDLE;
      step_q        <= '0;
      best_id_q     <= '0;
      best_prio_q   <= '0;
      winner_id_q   <= '0;
      winner_prio_q <= '0;
      irq_q         <= 1'b0;
      claim_ack_q   <= 1'b0;
      claim_id_q    <= '0;
    end else begin
      // The claim always returns the winner registered before this edge.
      claim_ack_q <= claim_req_i;
      claim_id_q  <= (claim_req_i && irq_q) ? winner_id_q : '0;

      if (!en_i) begin
        state_q       <= ST_IDLE;
        step_q        <= '0;
        best_id_q     <= '0;
        best_prio_q   <= '0;
        winner_id_q   <= '0;
        winner_prio_q <= '0;
        irq_q         <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q     <= ST_SCAN;
            step_q      <= '0;
            best_id_q   <= '0;
            best_prio_q <= '0;
          end
          ST_SCAN, ST_UPDATE: begin
            if (claim_req_i) begin
              // Claim wins over any partial or completed scan.
              state_q       <= ST_SCAN;
              step_q        <= '0;
              best_id_q     <= '0;
              best_prio_q   <= '0;
              winner_id_q   <= '0;
              winner_prio_q <= '0;
              irq_q         <= 1'b0;
            end else if (state_q == ST_SCAN) begin
              // Later steps carry higher ids, so only a strictly greater
              // priority may displace the running best.
              if (tree_vld && (tree_prio > best_prio_q)) begin
                best_id_q   <= tree_id;
                best_prio_q <= tree_prio;
              end
              if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                state_q <= ST_UPDATE;
              end else begin
                step_q <= step_q + 1'b1;
              end
            end else begin
              winner_id_q   <= best_id_q;
              winner_prio_q <= best_prio_q;
              irq_q         <= (best_prio_q > threshold_i);
              state_q       <= ST_SCAN;
              step_q        <= '0;
              best_id_q     <= '0;
              best_prio_q   <= '0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            step_q  <= '0;
          end
        endcase
      end
    end
  end

  assign winner_id_o   = winner_id_q;
  assign winner_prio_o = winner_prio_q;
  assign irq_o         = irq_q;
  assign claim_ack_o   = claim_ack_q;
  assign claim_id_o    = claim_id_q;
  // A commit happens only if the UPDATE cycle is not overridden.
  assign scan_done_o   = (state_q == ST_UPDATE) & en_i & ~claim_req_i;

endmodule

// File: tb/tb_plic_seq_arbiter.sv
module tb_plic_seq_arbiter;
  import plic_pkg::*;

  localparam int NI = 64;
  localparam int PB = 5;
  localparam int LN = 8;
  localparam int IW = 6;

  logic           pclk = 1'b0;
  logic           prst;
  logic           en;
  logic [NI-1:0]  pend;
  logic [NI-1:0]  ien;
  logic [NI*PB-1:0] pri;
  logic [PB-1:0]  thr;
  logic           claim;
  logic [IW-1:0]  win_id;
  logic [PB-1:0]  win_prio;
  logic           irq;
  logic           done;
  logic           ack;
  logic [IW-1:0]  cid;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 pclk = ~pclk;

  plic_seq_arbiter #(.NUM_IRQ(NI), .PRIO_BIT(PB), .LANES(LN)) dut (
    .pclk_i        (pclk),
    .prst_i        (prst),
    .en_i          (en),
    .int_pending_i (pend),
    .int_en_i      (ien),
    .pri_lvl_i     (pri),
    .threshold_i   (thr),
    .claim_req_i   (claim),
    .winner_id_o   (win_id),
    .winner_prio_o (win_prio),
    .irq_o         (irq),
    .scan_done_o   (done),
    .claim_ack_o   (ack),
    .claim_id_o    (cid)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic clr_irqs();
    pend = '0;
    ien  = '0;
    pri  = '0;
  endtask

  task automatic set_irq(input int id, input int p, input bit enable);
    pend[id] = 1'b1;
    ien[id]  = enable;
    pri[id*PB +: PB] = PB'(p);
  endtask

  // Advance until scan_done_o is seen; returns cycles taken.
  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (!done && cnt < 40);
    if (!done) chk_eq("scan_done_timeout", 0, 1);
  endtask

  task automatic wait_step(input int s);
    int k = 0;
    while (!(dut.state_q == ST_SCAN && dut.step_q == 3'(s)) && k < 40) begin
      cyc();
      k++;
    end
    if (k >= 40) chk_eq("wait_step_timeout", 0, 1);
  endtask

  initial begin
    prst = 1'b1; en = 1'b0; claim = 1'b0; thr = '0;
    clr_irqs();
    #2;
    chk_eq("rst_win_id", win_id, 0);
    chk_eq("rst_irq", irq, 0);
    chk_eq("rst_ack", ack, 0);
    repeat (3) cyc();

    // Idle system: scan period and empty result
    prst = 1'b0; en = 1'b1;
    wait_done(n);
    chk_eq("first_scan_latency", n, 9);
    wait_done(n);
    chk_eq("scan_period", n, 9);
    cyc();
    chk_eq("empty_win_id", win_id, 0);
    chk_eq("empty_win_prio", win_prio, 0);
    chk_eq("empty_irq", irq, 0);

    // Equal priorities in different steps: lowest id wins
    set_irq(5, 3, 1); set_irq(40, 3, 1); thr = 5'd2;
    wait_done(n); wait_done(n); cyc();
    chk_eq("tie_win_id", win_id, 5);
    chk_eq("tie_win_prio", win_prio, 3);
    chk_eq("tie_irq", irq, 1);

    // Ineligible sources (disabled, id 0) are ignored; later strictly-greater wins
    clr_irqs(); thr = 5'd0;
    set_irq(0, 31, 1); set_irq(30, 31, 0);
    set_irq(3, 4, 1); set_irq(6, 4, 1); set_irq(9, 2, 1); set_irq(50, 6, 1);
    wait_done(n); wait_done(n); cyc();
    chk_eq("mix_win_id", win_id, 50);
    chk_eq("mix_win_prio", win_prio, 6);
    clr_irqs();
    set_irq(3, 4, 1); set_irq(6, 4, 1); set_irq(9, 2, 1);
    wait_done(n); wait_done(n); cyc();
    chk_eq("lane_tie_win_id", win_id, 3);

    // Highest id, priority equal to threshold -> no irq
    clr_irqs(); set_irq(63, 7, 1); thr = 5'd7;
    wait_done(n); wait_done(n); cyc();
    chk_eq("thr_win_id", win_id, 63);
    chk_eq("thr_win_prio", win_prio, 7);
    chk_eq("thr_irq", irq, 0);

    // Claim coinciding with UPDATE
    clr_irqs(); set_irq(12, 9, 1); thr = 5'd0;
    wait_done(n); wait_done(n); cyc();
    chk_eq("pre_claim_win_id", win_id, 12);
    chk_eq("pre_claim_irq", irq, 1);
    wait_done(n);
    claim = 1'b1;
    #1;
    chk_eq("done_suppressed", done, 0);
    cyc();
    claim = 1'b0;
    chk_eq("claim_ack", ack, 1);
    chk_eq("claim_id", cid, 12);
    chk_eq("claim_irq_clr", irq, 0);
    chk_eq("claim_win_clr", win_id, 0);
    chk_eq("claim_step0", dut.step_q, 0);
    chk_eq("claim_state", dut.state_q, ST_SCAN);
    cyc();
    chk_eq("ack_pulse", ack, 0);
    chk_eq("cid_idle", cid, 0);

    // Disable mid-scan, then claim in IDLE
    wait_done(n);
    chk_eq("post_claim_period", n, 7);
    cyc();
    chk_eq("rescan_win_id", win_id, 12);
    chk_eq("rescan_irq", irq, 1);
    wait_step(4);
    en = 1'b0;
    cyc();
    chk_eq("dis_state", dut.state_q, ST_IDLE);
    chk_eq("dis_win_id", win_id, 0);
    chk_eq("dis_irq", irq, 0);
    claim = 1'b1;
    cyc();
    claim = 1'b0;
    chk_eq("idle_claim_ack", ack, 1);
    chk_eq("idle_claim_id", cid, 0);
    chk_eq("idle_claim_state", dut.state_q, ST_IDLE);

    // Asynchronous reset mid-scan with claim in flight
    clr_irqs(); set_irq(20, 5, 1);
    en = 1'b1;
    wait_done(n); cyc();
    chk_eq("pre_rst_win_id", win_id, 20);
    wait_step(6);
    prst = 1'b1; claim = 1'b1;
    #2;
    chk_eq("arst_win_id", win_id, 0);
    chk_eq("arst_irq", irq, 0);
    chk_eq("arst_step", dut.step_q, 0);
    cyc();
    claim = 1'b0;
    chk_eq("arst_no_ack", ack, 0);
    cyc();
    prst = 1'b0;
    wait_done(n);
    chk_eq("post_rst_latency", n, 9);
    cyc();
    chk_eq("post_rst_win_id", win_id, 20);
    chk_eq("post_rst_win_prio", win_prio, 5);
    chk_eq("post_rst_irq", irq, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
